// File: rtl/gba_irq_controller.sv
// gba_irq_controller: edge-latched IF flags gated by IE/IME into a registered IRQ, source id and wake line.
module gba_irq_controller #(
    parameter int NUM_SRC = 14,
    parameter int ID_W = 4
) (
    input  logic               clock_16,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [1:0]         reg_sel,
    input  logic               wr_en,
    input  logic [15:0]        wr_data,
    output logic [15:0]        rd_data,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic               wake
);
    logic [NUM_SRC-1:0] src_q, ie, if_r, rise, clr, pend;
    logic               ime;
    logic [ID_W-1:0]    low_id;

    assign rise = irq_src & ~src_q;
    assign clr  = (wr_en && reg_sel == 2'd1) ? wr_data[NUM_SRC-1:0] : '0;
    assign pend = ie & if_r;

    always_comb begin
        low_id = '1;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pend[i]) low_id = ID_W'(i);
    end

    always_comb
        rd_data = reg_sel == 2'd0 ? 16'(ie) :
                  reg_sel == 2'd1 ? 16'(if_r) :
                  reg_sel == 2'd2 ? 16'(ime) : 16'h0000;

    always_ff @(posedge clock_16 or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            ie     <= '0;
            if_r   <= '0;
            ime    <= 1'b0;
            irq    <= 1'b0;
            wake   <= 1'b0;
            irq_id <= '1;
        end else begin
            src_q  <= irq_src;
            if_r   <= (if_r & ~clr) | rise;
            if (wr_en && reg_sel == 2'd0) ie <= wr_data[NUM_SRC-1:0];
            if (wr_en && reg_sel == 2'd2) ime <= wr_data[0];
            wake   <= |pend;
            irq    <= ime & (|pend);
            irq_id <= low_id;
        end
    end
endmodule

// File: tb/tb_gba_irq_controller.sv
// tb_gba_irq_controller: directed tests of edge latching, W1C, enable gating and async reset.
module tb_gba_irq_controller;
    logic        clock_16 = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] irq_src = '0;
    logic [1:0]  reg_sel = '0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        irq;
    logic [3:0]  irq_id;
    logic        wake;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] r;

    gba_irq_controller dut (
        .clock_16(clock_16), .reset(reset), .irq_src(irq_src), .reg_sel(reg_sel),
        .wr_en(wr_en), .wr_data(wr_data), .rd_data(rd_data), .irq(irq),
        .irq_id(irq_id), .wake(wake)
    );

    always #5 clock_16 = ~clock_16;

    task automatic step();
        @(posedge clock_16);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] data);
        reg_sel = sel;
        wr_data = data;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [15:0] data);
        reg_sel = sel;
        #1;
        data = rd_data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_checks++; if (wake !== 1'b0) begin n_fail++; $display("FAIL reset_wake: got %b expected 0", wake); end
        n_checks++; if (irq_id !== 4'hF) begin n_fail++; $display("FAIL reset_id: got %h expected f", irq_id); end
        do_reset();
        rd(2'd1, r);
        n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL reset_if: got %h expected 0000", r); end
    endtask

    task automatic test_basic();
        do_reset();
        wr(2'd0, 16'h0008);
        wr(2'd2, 16'h0001);
        irq_src = 14'h0008;
        step();
        irq_src = '0;
        rd(2'd1, r);
        n_checks++; if (r !== 16'h0008) begin n_fail++; $display("FAIL basic_if: got %h expected 0008", r); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_early: got %b expected 0", irq); end
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq: got %b expected 1", irq); end
        n_checks++; if (irq_id !== 4'd3) begin n_fail++; $display("FAIL basic_id: got %h expected 3", irq_id); end
        wr(2'd1, 16'h0008);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq_hold: got %b expected 1", irq); end
        step();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_clr: got %b expected 0", irq); end
        n_checks++; if (irq_id !== 4'hF) begin n_fail++; $display("FAIL basic_id_clr: got %h expected f", irq_id); end
    endtask

    task automatic test_enable();
        do_reset();
        wr(2'd0, 16'hFFFF);
        rd(2'd0, r);
        n_checks++; if (r !== 16'h3FFF) begin n_fail++; $display("FAIL ie_width: got %h expected 3fff", r); end
        irq_src = 14'h0020;
        step();
        irq_src = '0;
        step();
        n_checks++; if (wake !== 1'b1) begin n_fail++; $display("FAIL en_wake: got %b expected 1", wake); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL en_irq_off: got %b expected 0", irq); end
        n_checks++; if (irq_id !== 4'd5) begin n_fail++; $display("FAIL en_id: got %h expected 5", irq_id); end
        wr(2'd2, 16'h0001);
        rd(2'd2, r);
        n_checks++; if (r !== 16'h0001) begin n_fail++; $display("FAIL ime_read: got %h expected 0001", r); end
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL en_irq_on: got %b expected 1", irq); end
    endtask

    task automatic test_set_wins();
        irq_src = 14'h0004;
        reg_sel = 2'd1;
        wr_data = 16'h0004;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        irq_src = '0;
        rd(2'd1, r);
        n_checks++; if (r !== 16'h0024) begin n_fail++; $display("FAIL setwins_if: got %h expected 0024", r); end
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL setwins_irq: got %b expected 1", irq); end
        n_checks++; if (irq_id !== 4'd2) begin n_fail++; $display("FAIL setwins_id: got %h expected 2", irq_id); end
        wr(2'd1, 16'h0000);
        rd(2'd1, r);
        n_checks++; if (r !== 16'h0024) begin n_fail++; $display("FAIL w0_noop: got %h expected 0024", r); end
        wr(2'd0, 16'h0000);
        step();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ie_off_irq: got %b expected 0", irq); end
        rd(2'd1, r);
        n_checks++; if (r !== 16'h0024) begin n_fail++; $display("FAIL ie_keeps_if: got %h expected 0024", r); end
    endtask

    task automatic test_priority();
        do_reset();
        wr(2'd0, 16'h3FFF);
        wr(2'd2, 16'h0001);
        irq_src = 14'h0202;
        step();
        irq_src = '0;
        step();
        n_checks++; if (irq_id !== 4'd1) begin n_fail++; $display("FAIL prio_id1: got %h expected 1", irq_id); end
        wr(2'd1, 16'h0002);
        step();
        n_checks++; if (irq_id !== 4'd9) begin n_fail++; $display("FAIL prio_id9: got %h expected 9", irq_id); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL prio_irq: got %b expected 1", irq); end
        wr(2'd1, 16'h0200);
        step();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL prio_irq_off: got %b expected 0", irq); end
        n_checks++; if (irq_id !== 4'hF) begin n_fail++; $display("FAIL prio_id_none: got %h expected f", irq_id); end
        n_checks++; if (wake !== 1'b0) begin n_fail++; $display("FAIL prio_wake: got %b expected 0", wake); end
    endtask

    task automatic test_held();
        reset = 1'b1;
        irq_src = 14'h0001;
        #2;
        reset = 1'b0;
        step();
        rd(2'd1, r);
        n_checks++; if (r !== 16'h0001) begin n_fail++; $display("FAIL held_first: got %h expected 0001", r); end
        for (int i = 0; i < 5; i++) step();
        wr(2'd1, 16'h0001);
        for (int i = 0; i < 14; i++) step();
        rd(2'd1, r);
        n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL held_no_reedge: got %h expected 0000", r); end
        irq_src = '0;
        step();
        rd(2'd1, r);
        n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL held_fall: got %h expected 0000", r); end
        irq_src = 14'h0001;
        step();
        rd(2'd1, r);
        n_checks++; if (r !== 16'h0001) begin n_fail++; $display("FAIL held_rerise: got %h expected 0001", r); end
        irq_src = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        wr(2'd0, 16'h00FF);
        wr(2'd2, 16'h0001);
        irq_src = 14'h00FF;
        step();
        irq_src = '0;
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ar_pre_irq: got %b expected 1", irq); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq: got %b expected 0", irq); end
        n_checks++; if (wake !== 1'b0) begin n_fail++; $display("FAIL ar_wake: got %b expected 0", wake); end
        n_checks++; if (irq_id !== 4'hF) begin n_fail++; $display("FAIL ar_id: got %h expected f", irq_id); end
        rd(2'd0, r);
        n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL ar_ie: got %h expected 0000", r); end
        rd(2'd1, r);
        n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL ar_if: got %h expected 0000", r); end
        rd(2'd2, r);
        n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL ar_ime: got %h expected 0000", r); end
        reset = 1'b0;
        step();
        wr(2'd3, 16'hFFFF);
        rd(2'd3, r);
        n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL rsv_read: got %h expected 0000", r); end
        rd(2'd0, r);
        n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL rsv_ie: got %h expected 0000", r); end
        rd(2'd2, r);
        n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL rsv_ime: got %h expected 0000", r); end
        step();
        n_checks++; if (wake !== 1'b0) begin n_fail++; $display("FAIL ar_no_survivor: got %b expected 0", wake); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable();
        test_set_wins();
        test_priority();
        test_held();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gba_irq_controller.md
Name: gba_irq_controller

Overview:
- Receiving end of the peripheral interrupt lines (timer genIRQ, DMA, keypad, serial, LCD).
- Detects rising edges on each source and latches them into the interrupt-request flags (IF).
- Gates the flags with the enable mask (IE) and the master enable (IME) and drives a single registered IRQ line plus a source ID to the CPU.
- Register behaviour follows the GBA IE/IF/IME model: IF bits are cleared by writing 1 to them (write-1-to-clear).

Parameters:
- NUM_SRC, 14, number of interrupt sources; bit i of every mask corresponds to source i.
- ID_W, 4, width of irq_id; must satisfy 2^ID_W > NUM_SRC.

Ports:
- clock_16  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- irq_src  input  NUM_SRC  per-source request lines (level or pulse); rising edge is the event.
- reg_sel  input  2  register select: 0=IE, 1=IF, 2=IME, 3=reserved.
- wr_en  input  1  one-cycle write strobe, qualified by reg_sel.
- wr_data  input  16  write data.
- rd_data  output  16  combinational read of the selected register.
- irq  output  1  registered interrupt request to the CPU, active-high.
- irq_id  output  ID_W  registered index of the lowest-numbered pending enabled source; all-ones when none.
- wake  output  1  registered; high when (IE & IF) != 0, regardless of IME (HALT exit).

Behaviour:
- Reset (async): IE=0, IF=0, IME=0, src_q=0, irq=0, wake=0, irq_id=all-ones.
- Edge detect:
  - src_q <= irq_src every cycle.
  - rise = irq_src & ~src_q.
  - A source held high across reset release yields exactly one edge on the first clock after release.
  - A source held high continuously yields no further edges.
- IF update (per bit, every cycle): IF <= (IF & ~clr) | rise.
  - clr = wr_data[NUM_SRC-1:0] when wr_en && reg_sel==1, else 0.
  - If set and clear hit the same bit in the same cycle, set wins and the bit ends at 1.
  - Writing 0 to an IF bit has no effect.
- IE write (wr_en && reg_sel==0): IE <= wr_data[NUM_SRC-1:0]; upper bits are ignored.
- IME write (wr_en && reg_sel==2): IME <= wr_data[0].
- reg_sel==3 write: ignored, no state change.
- Reads (combinational, no side effects):
  - Selected register zero-extended to 16 bits.
  - IME reads as {15'b0, IME}.
  - reg_sel==3 reads 0.
  - A read in the same cycle as a write returns the pre-write value.
- Outputs, all registered from current register values, so one cycle after a register change:
  - pend = IE & IF.
  - wake <= |pend.
  - irq <= IME & |pend.
  - irq_id <= index of the lowest set bit of pend, or all-ones if pend==0; updated even when IME=0.
- Latency:
  - Source rises before edge N: IF bit set at edge N; irq/wake high at edge N+1.
  - IF clear at edge M: irq low at edge M+1, unless another enabled bit is pending.
- Enable changes: enabling IE or IME with a bit already pending asserts irq one cycle later. Disabling deasserts irq one cycle later. IF is never modified by IE/IME writes.
- Multiple simultaneous rises: all bits set in IF in the same cycle; irq_id reports the lowest index.
- Reset asserted mid-operation: all state clears immediately (asynchronous); no pending events survive.

Test Plan:
- Reset, IE=0x0008, IME=1; pulse irq_src[3] for one cycle -> IF=0x0008 at the next edge; irq=1, irq_id=3 one edge later; write IF=0x0008 -> irq=0 one edge after the write.
- IE=0x3FFF, IME=0; rise on src[5] -> wake=1, irq=0, irq_id=5; write IME=1 -> irq=1 next edge.
- Simultaneous rise on src[2] and write IF=0x0004 in the same cycle -> IF[2] remains 1, irq stays asserted.
- Rises on src[9] and src[1] together with IE=0x3FFF, IME=1 -> irq_id=1; clear IF bit 1 -> irq_id=9 next edge, irq stays 1; clear bit 9 -> irq=0, irq_id=0xF.
- irq_src[0] held high for 20 cycles -> IF[0] set once; after IF is cleared it stays 0 until the line falls and rises again.
- Assert reset with IF=0x00FF, IE=0x00FF, IME=1 -> IF/IE/IME/irq/wake=0 and irq_id=0xF immediately; reads of IE/IF/IME return 0; reg_sel=3 reads 0 and writes to it are ignored.
